// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async FIFO write port.
// Tags each beat with its owner ID; a watchdog revokes stalled owners.
//
// Ports:
//   clk_wr, wrst_n            write clock, async active-low reset
//   req_valid/last/data       per-requester beat stream (NREQ lanes)
//   req_ready                 per-requester accept
//   fifo_full                 FIFO full flag
//   fifo_wren, fifo_wdata     FIFO write strobe and {id, payload}
//   grant_id, busy            current owner, burst in progress
//   err_timeout, err_id       forced-release pulse, revoked owner
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 16,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                      clk_wr,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wren,
  output logic [IDW+DATAWIDTH-1:0]  fifo_wdata,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      err_timeout,
  output logic [IDW-1:0]            err_id
);

  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);
  localparam logic [CW-1:0]  CNT_HIT = CW'(TIMEOUT-1);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_grant;
  logic [IDW-1:0]  r_rr_ptr;
  logic [CW-1:0]   r_idle_cnt;
  logic            r_err;
  logic [IDW-1:0]  r_err_id;

  state_t          w_state_nxt;
  logic [IDW-1:0]  w_grant_nxt;
  logic [IDW-1:0]  w_rr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_err_nxt;
  logic [IDW-1:0]  w_err_id_nxt;

  logic            w_busy;
  logic            w_own_valid;
  logic            w_own_last;
  logic [DATAWIDTH-1:0] w_own_data;
  logic            w_xfer;
  logic            w_hit;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_scan;

  // Owner lane selection.
  assign w_busy      = (r_state == S_BURST);
  assign w_own_valid = req_valid[r_grant];
  assign w_own_last  = req_last[r_grant];
  assign w_own_data  =
    req_data[int'(r_grant)*DATAWIDTH +: DATAWIDTH];

  assign w_xfer = w_busy & w_own_valid & ~fifo_full;

  // Only an absent owner counts; full stalls keep valid high.
  assign w_hit  = w_busy & ~w_own_valid &
                  (r_idle_cnt == CNT_HIT);

  // Scan starts one past the last winner, wrapping at NREQ-1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = (w_scan == LAST_ID) ? '0 : w_scan + 1'b1;
      if (!w_found && req_valid[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_busy) begin
      req_ready[r_grant] = ~fifo_full;
    end
  end

  assign fifo_wren  = w_xfer;
  assign fifo_wdata = w_xfer ? {r_grant, w_own_data} : '0;

  assign grant_id    = r_grant;
  assign busy        = w_busy;
  assign err_timeout = r_err;
  assign err_id      = r_err_id;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_nxt     = r_rr_ptr;
    w_cnt_nxt    = r_idle_cnt;
    w_err_nxt    = 1'b0;
    w_err_id_nxt = r_err_id;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = S_BURST;
          w_grant_nxt = w_winner;
        end
      end
      S_BURST: begin
        if (w_xfer && w_own_last) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = r_grant;
          w_cnt_nxt   = '0;
        end else if (w_own_valid) begin
          w_cnt_nxt = '0;
        end else if (w_hit) begin
          w_state_nxt  = S_IDLE;
          w_rr_nxt     = r_grant;
          w_cnt_nxt    = '0;
          w_err_nxt    = 1'b1;
          w_err_id_nxt = r_grant;
        end else if (r_idle_cnt != CNT_MAX) begin
          w_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_wr or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= LAST_ID;
      r_idle_cnt <= '0;
      r_err      <= 1'b0;
      r_err_id   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_idle_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_err_id   <= w_err_id_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven requesters,
// scoreboard of tagged FIFO writes and timeout events.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;
  localparam int IDW  = 2;

  logic                 clk_wr = 1'b0;
  logic                 wrst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last  = '0;
  logic [NREQ*DW-1:0]   req_data  = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full = 1'b0;
  logic                 fifo_wren;
  logic [IDW+DW-1:0]    fifo_wdata;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err_timeout;
  logic [IDW-1:0]       err_id;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DATAWIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_wr(clk_wr), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wren(fifo_wren),
    .fifo_wdata(fifo_wdata), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout),
    .err_id(err_id)
  );

  initial forever #5 clk_wr = ~clk_wr;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t             dq [NREQ][$];
  logic [IDW+DW-1:0] exp_q [$];
  logic [IDW-1:0]    err_q [$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc = 0;
  int                last_cyc [NREQ];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic fail_wait(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not reached in budget", nm);
  endtask

  // Issue a beat and record its expected tagged FIFO word.
  task automatic send(input int r,
                      input logic [DW-1:0] d,
                      input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    dq[r].push_back(b);
    exp_q.push_back({IDW'(r), d});
  endtask

  function automatic bit all_empty();
    bit e;
    e = (exp_q.size() == 0);
    for (int i = 0; i < NREQ; i++)
      if (dq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_busy(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk_wr); #2;
      if (busy) ok = 1'b1;
    end
    if (!ok) fail_wait(nm);
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk_wr); #2;
      if (all_empty() && !busy) ok = 1'b1;
    end
    if (!ok) fail_wait(nm);
    repeat (2) @(posedge clk_wr);
    #2;
  endtask

  initial forever begin
    @(posedge clk_wr);
    cyc++;
  end

  // Requester model: present queue head, pop on handshake.
  initial forever begin
    logic [NREQ-1:0] hs;
    @(negedge clk_wr);
    for (int i = 0; i < NREQ; i++) begin
      if (dq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = dq[i][0].l;
        req_data[i*DW +: DW] = dq[i][0].d;
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    #4;
    hs = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (hs[i] && dq[i].size() > 0) void'(dq[i].pop_front());
  end

  // Monitor: sampled just before the edge that commits.
  initial forever begin
    logic [IDW+DW-1:0] e;
    logic [IDW-1:0]    ei;
    @(negedge clk_wr);
    #4;
    if (fifo_wren) begin
      chk("wren_while_full", {31'b0, fifo_full}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat: got 0x%0h expected none",
                 fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {22'b0, fifo_wdata}, {22'b0, e});
        last_cyc[fifo_wdata[IDW+DW-1:DW]] = cyc;
      end
    end
    if (err_timeout) begin
      if (err_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL err_pulse: got id %0d expected none",
                 err_id);
      end else begin
        ei = err_q.pop_front();
        chk("err_id", {30'b0, err_id}, {30'b0, ei});
        // Pulse is visible TO edges after the last beat edge.
        chk("to_delay", cyc - last_cyc[ei], TO + 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    bit ok;
    // Reset with every requester valid.
    send(0, 8'h11, 1'b1);
    send(1, 8'h12, 1'b1);
    send(2, 8'h13, 1'b1);
    send(3, 8'h14, 1'b1);
    send(0, 8'h15, 1'b1);
    repeat (2) @(posedge clk_wr);
    #2;
    chk("rst_valid_in", {28'b0, req_valid}, 32'hF);
    chk("rst_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_wren", {31'b0, fifo_wren}, 32'd0);
    chk("rst_wdata", {22'b0, fifo_wdata}, 32'd0);
    chk("rst_grant", {30'b0, grant_id}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err_timeout}, 32'd0);
    chk("rst_err_id", {30'b0, err_id}, 32'd0);
    wrst_n = 1'b1;
    @(posedge clk_wr);
    #2;
    chk("first_busy", {31'b0, busy}, 32'd1);
    chk("first_grant", {30'b0, grant_id}, 32'd0);
    chk("first_ready", {28'b0, req_ready}, 32'h1);
    wait_done("t2_rr");

    // Burst lock: req0 keeps the port while req2 waits.
    for (int b = 0; b < 5; b++)
      send(0, 8'h31 + 8'(b), (b == 4));
    wait_busy("t3_busy");
    chk("t3_grant", {30'b0, grant_id}, 32'd0);
    send(2, 8'h41, 1'b1);
    @(posedge clk_wr); #2;
    chk("t3_ready_lock", {28'b0, req_ready}, 32'h1);
    wait_done("t3_lock");

    // Backpressure mid-burst.
    for (int b = 0; b < 6; b++)
      send(3, 8'h71 + 8'(b), (b == 5));
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk_wr); #2;
      if (dq[3].size() == 4) ok = 1'b1;
    end
    if (!ok) fail_wait("t4_mid");
    fifo_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_wr); #2;
      chk("bp_ready", {28'b0, req_ready}, 32'd0);
      chk("bp_wren", {31'b0, fifo_wren}, 32'd0);
      chk("bp_err", {31'b0, err_timeout}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
    end
    fifo_full = 1'b0;
    wait_done("t4_bp");

    // Timeout: req1 stops after two beats, req2 waits.
    send(1, 8'h51, 1'b0);
    send(1, 8'h52, 1'b0);
    err_q.push_back(IDW'(1));
    wait_busy("t5_busy");
    chk("t5_grant", {30'b0, grant_id}, 32'd1);
    send(2, 8'h61, 1'b1);
    wait_done("t5_to");
    chk("t5_err_seen", err_q.size(), 32'd0);

    // Mid-burst reset; first a burst from req0 so the
    // pointer would favour req1 if it were not reset.
    send(0, 8'h81, 1'b1);
    wait_done("t6_pre");
    for (int b = 0; b < 5; b++)
      send(0, 8'h91 + 8'(b), (b == 4));
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk_wr); #2;
      if (dq[0].size() == 3) ok = 1'b1;
    end
    if (!ok) fail_wait("t6_third");
    wrst_n = 1'b0;
    #1;
    chk("mr_valid_in", {31'b0, req_valid[0]}, 32'd1);
    chk("mr_wren", {31'b0, fifo_wren}, 32'd0);
    chk("mr_wdata", {22'b0, fifo_wdata}, 32'd0);
    chk("mr_ready", {28'b0, req_ready}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_err_id", {30'b0, err_id}, 32'd0);
    chk("mr_left", exp_q.size(), 32'd3);
    for (int i = 0; i < NREQ; i++) dq[i].delete();
    exp_q.delete();
    send(0, 8'hA1, 1'b1);
    send(1, 8'hA2, 1'b1);
    repeat (2) @(posedge clk_wr);
    #2;
    wrst_n = 1'b1;
    wait_done("t6_after");

    chk("exp_left", exp_q.size(), 32'd0);
    chk("err_left", err_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
